// File: rtl/bus_rv32_fifo_responder.sv
// ---------------------------------------------------------------------------
// cpu_reg_package: bus widths shared by the CPU register blocks.
//
// bus_rv32_fifo_responder: four-register CPU window (TXDATA, RXDATA, STATUS,
// CTRL) in front of two small FIFOs. The CPU fills the TX FIFO and an
// external reader drains it. An external writer fills the RX FIFO and the
// CPU drains it.
//
// Ports
//   clk_i, reset_i       clock, synchronous active-high reset
//   address_i            CPU bus address (address_width bits)
//   we_i                 CPU register-write strobe
//   we_ram_i             RAM byte enables (not used here)
//   data_i               CPU write data
//   data_o               registered read data (0 when not addressed)
//   irq_o                registered interrupt request
//   module_busy_o        registered "TX FIFO not empty"
//   ext_push_*           external writer into the RX FIFO
//   ext_pop_*            external reader of the TX FIFO (show-ahead head)
//
// Handshakes: a transfer on ext_push_* or ext_pop_* happens on a rising clk
// edge where valid and ready are both 1. Valid never depends on ready.
// Ready may depend on FIFO fill and reset, but never on valid.
// ---------------------------------------------------------------------------
package cpu_reg_package;
   localparam int address_width = 32;
   localparam int data_width    = 32;
endpackage

module bus_rv32_fifo_responder
   import cpu_reg_package::*;
#(
   parameter logic [address_width-1:0] BASE_ADDR = 32'h0000_9000,
   parameter int                       DEPTH     = 8
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic [address_width-1:0] address_i,
   input  logic                     we_i,
   input  logic [3:0]               we_ram_i,
   input  logic [data_width-1:0]    data_i,
   output logic [data_width-1:0]    data_o,
   output logic                     irq_o,
   output logic                     module_busy_o,
   input  logic                     ext_push_valid_i,
   input  logic [31:0]              ext_push_data_i,
   output logic                     ext_push_ready_o,
   output logic                     ext_pop_valid_o,
   output logic [31:0]              ext_pop_data_o,
   input  logic                     ext_pop_ready_i
);

   localparam int         PW      = $clog2(DEPTH);
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   // Byte enables belong to the RAM path on the shared bus.
   logic unused_we_ram;
   assign unused_we_ram = ^we_ram_i;

   // Storage (not reset; pointers and counts define validity)
   logic [31:0] rx_mem_q [DEPTH];
   logic [31:0] tx_mem_q [DEPTH];

   // State
   logic [PW-1:0]         rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
   logic [PW-1:0]         tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
   logic [3:0]            rx_count_q, rx_count_d, tx_count_q, tx_count_d;
   logic                  irq_en_q, irq_en_d;
   logic                  tx_ovf_q, tx_ovf_d;
   logic                  rx_udf_q, rx_udf_d;
   logic                  rx_sel_prev_q, rx_sel_prev_d;
   logic [data_width-1:0] data_q, data_d;
   logic                  irq_q, irq_d;
   logic                  busy_q, busy_d;

   // Decode and handshake terms
   logic        sel_tx, sel_rx, sel_status, sel_ctrl;
   logic        rx_empty, rx_full, tx_empty, tx_full;
   logic        rx_push, rx_rd, rx_rd_first, rx_pop;
   logic        tx_write, tx_push, tx_pop, ctrl_write;
   logic [31:0] status_word;

   assign rx_empty = (rx_count_q == 4'd0);
   assign rx_full  = (rx_count_q == DEPTH_C);
   assign tx_empty = (tx_count_q == 4'd0);
   assign tx_full  = (tx_count_q == DEPTH_C);

   assign ext_push_ready_o = !rx_full && !reset_i;
   assign ext_pop_valid_o  = !tx_empty && !reset_i;
   assign ext_pop_data_o   = tx_mem_q[tx_rd_ptr_q];

   assign data_o        = data_q;
   assign irq_o         = irq_q;
   assign module_busy_o = busy_q;

   always_comb begin
      sel_tx     = (address_i == BASE_ADDR);
      sel_rx     = (address_i == BASE_ADDR + address_width'(4));
      sel_status = (address_i == BASE_ADDR + address_width'(8));
      sel_ctrl   = (address_i == BASE_ADDR + address_width'(12));

      rx_push     = ext_push_valid_i && ext_push_ready_o;
      rx_rd       = !we_i && sel_rx;
      // Only the first cycle of a held RXDATA read consumes an entry.
      rx_rd_first = rx_rd && !rx_sel_prev_q;
      rx_pop      = rx_rd_first && !rx_empty;

      tx_write   = we_i && sel_tx;
      tx_push    = tx_write && !tx_full;
      tx_pop     = ext_pop_valid_o && ext_pop_ready_i;
      ctrl_write = we_i && sel_ctrl;

      status_word        = '0;
      status_word[0]     = rx_empty;
      status_word[1]     = rx_full;
      status_word[2]     = tx_empty;
      status_word[3]     = tx_full;
      status_word[4]     = tx_ovf_q;
      status_word[5]     = rx_udf_q;
      status_word[11:8]  = rx_count_q;
      status_word[19:16] = tx_count_q;
   end

   always_comb begin
      rx_wr_ptr_d   = rx_wr_ptr_q;
      rx_rd_ptr_d   = rx_rd_ptr_q;
      rx_count_d    = rx_count_q;
      tx_wr_ptr_d   = tx_wr_ptr_q;
      tx_rd_ptr_d   = tx_rd_ptr_q;
      tx_count_d    = tx_count_q;
      irq_en_d      = irq_en_q;
      tx_ovf_d      = tx_ovf_q;
      rx_udf_d      = rx_udf_q;
      rx_sel_prev_d = rx_rd;
      data_d        = '0;

      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + PW'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + PW'(1);
      if (rx_push && !rx_pop)      rx_count_d = rx_count_q + 4'd1;
      else if (!rx_push && rx_pop) rx_count_d = rx_count_q - 4'd1;

      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + PW'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + PW'(1);
      if (tx_push && !tx_pop)      tx_count_d = tx_count_q + 4'd1;
      else if (!tx_push && tx_pop) tx_count_d = tx_count_q - 4'd1;

      // Clears first, sets afterwards: a same-cycle set wins.
      if (ctrl_write) begin
         irq_en_d = data_i[0];
         if (data_i[1]) tx_ovf_d = 1'b0;
         if (data_i[2]) rx_udf_d = 1'b0;
      end
      if (tx_write && tx_full)     tx_ovf_d = 1'b1;
      if (rx_rd_first && rx_empty) rx_udf_d = 1'b1;

      // Reads return 0 unless a readable register is addressed; a held
      // RXDATA read keeps returning the word from the first cycle.
      if (!we_i) begin
         if (sel_rx) begin
            if (rx_rd_first) data_d = rx_empty ? '0 : rx_mem_q[rx_rd_ptr_q];
            else             data_d = data_q;
         end else if (sel_status) begin
            data_d = status_word;
         end else if (sel_ctrl) begin
            data_d = {31'b0, irq_en_q};
         end
      end

      irq_d  = irq_en_q && (!rx_empty || tx_ovf_q || rx_udf_q);
      busy_d = !tx_empty;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rx_wr_ptr_q   <= '0;
         rx_rd_ptr_q   <= '0;
         rx_count_q    <= '0;
         tx_wr_ptr_q   <= '0;
         tx_rd_ptr_q   <= '0;
         tx_count_q    <= '0;
         irq_en_q      <= 1'b0;
         tx_ovf_q      <= 1'b0;
         rx_udf_q      <= 1'b0;
         rx_sel_prev_q <= 1'b0;
         data_q        <= '0;
         irq_q         <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         rx_wr_ptr_q   <= rx_wr_ptr_d;
         rx_rd_ptr_q   <= rx_rd_ptr_d;
         rx_count_q    <= rx_count_d;
         tx_wr_ptr_q   <= tx_wr_ptr_d;
         tx_rd_ptr_q   <= tx_rd_ptr_d;
         tx_count_q    <= tx_count_d;
         irq_en_q      <= irq_en_d;
         tx_ovf_q      <= tx_ovf_d;
         rx_udf_q      <= rx_udf_d;
         rx_sel_prev_q <= rx_sel_prev_d;
         data_q        <= data_d;
         irq_q         <= irq_d;
         busy_q        <= busy_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rx_push)             rx_mem_q[rx_wr_ptr_q] <= ext_push_data_i;
      if (tx_push && !reset_i) tx_mem_q[tx_wr_ptr_q] <= data_i;
   end

endmodule

// File: tb/tb_bus_rv32_fifo_responder.sv
module tb_bus_rv32_fifo_responder;

   localparam logic [31:0] BASE  = 32'h0000_9000;
   localparam int          DEPTH = 8;

   // ---------------- clock / reset / DUT signals ----------------
   logic        clk = 1'b0;
   logic        reset_i;
   logic [31:0] address_i;
   logic        we_i;
   logic [3:0]  we_ram_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        irq_o;
   logic        module_busy_o;
   logic        ext_push_valid_i;
   logic [31:0] ext_push_data_i;
   logic        ext_push_ready_o;
   logic        ext_pop_valid_o;
   logic [31:0] ext_pop_data_o;
   logic        ext_pop_ready_i;

   always #5 clk = ~clk;

   bus_rv32_fifo_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
      .clk_i(clk), .reset_i(reset_i), .address_i(address_i), .we_i(we_i),
      .we_ram_i(we_ram_i), .data_i(data_i), .data_o(data_o), .irq_o(irq_o),
      .module_busy_o(module_busy_o),
      .ext_push_valid_i(ext_push_valid_i), .ext_push_data_i(ext_push_data_i),
      .ext_push_ready_o(ext_push_ready_o),
      .ext_pop_valid_o(ext_pop_valid_o), .ext_pop_data_o(ext_pop_data_o),
      .ext_pop_ready_i(ext_pop_ready_i)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] rx_m[$];
   logic [31:0] tx_m[$];
   logic        m_irq_en, m_tx_ovf, m_rx_udf, m_prev_rx;
   logic [31:0] m_data;
   logic [31:0] exp_q[$];
   logic        exp_irq, exp_busy;

   function automatic logic [31:0] m_status();
      logic [31:0] s;
      s = 32'(rx_m.size() == 0)
        | (32'(rx_m.size() == DEPTH) << 1)
        | (32'(tx_m.size() == 0) << 2)
        | (32'(tx_m.size() == DEPTH) << 3)
        | (32'(m_tx_ovf) << 4)
        | (32'(m_rx_udf) << 5)
        | (32'(rx_m.size()) << 8)
        | (32'(tx_m.size()) << 16);
      return s;
   endfunction

   task automatic model_step();
      logic [31:0] d;
      logic        push_ok, pop_ok, tx_was_full, rx_was_empty, mapped;
      d = 32'h0;
      if (reset_i) begin
         rx_m.delete(); tx_m.delete();
         m_irq_en = 0; m_tx_ovf = 0; m_rx_udf = 0; m_prev_rx = 0;
         exp_irq = 0; exp_busy = 0;
      end else begin
         exp_irq      = m_irq_en && (rx_m.size() != 0 || m_tx_ovf || m_rx_udf);
         exp_busy     = (tx_m.size() != 0);
         push_ok      = ext_push_valid_i && (rx_m.size() < DEPTH);
         pop_ok       = ext_pop_ready_i && (tx_m.size() != 0);
         tx_was_full  = (tx_m.size() == DEPTH);
         rx_was_empty = (rx_m.size() == 0);
         mapped = (address_i == BASE) || (address_i == BASE + 4) ||
                  (address_i == BASE + 8) || (address_i == BASE + 12);
         if (!we_i && mapped) begin
            if (address_i == BASE + 4) begin
               if (m_prev_rx)          d = m_data;
               else if (rx_was_empty)  m_rx_udf = 1;
               else                    d = rx_m.pop_front();
            end else if (address_i == BASE + 8) begin
               d = m_status();
            end else if (address_i == BASE + 12) begin
               d = 32'(m_irq_en);
            end
         end
         if (pop_ok) void'(tx_m.pop_front());
         if (we_i && address_i == BASE) begin
            if (tx_was_full) m_tx_ovf = 1;
            else             tx_m.push_back(data_i);
         end
         if (we_i && address_i == BASE + 12) begin
            m_irq_en = data_i[0];
            if (data_i[1]) m_tx_ovf = 0;
            if (data_i[2] && !(!we_i)) m_rx_udf = 0;
         end
         if (push_ok) rx_m.push_back(ext_push_data_i);
         m_prev_rx = !we_i && (address_i == BASE + 4);
      end
      m_data = d;
      exp_q.push_back(d);
   endtask

   // One clock cycle with the currently driven inputs; checks handshake
   // outputs before the edge and registered outputs after it.
   task automatic do_cycle();
      logic [31:0] e;
      #1;
      chk("push_ready", 32'(ext_push_ready_o), 32'(!reset_i && rx_m.size() < DEPTH));
      chk("pop_valid", 32'(ext_pop_valid_o), 32'(!reset_i && tx_m.size() != 0));
      if (!reset_i && tx_m.size() != 0) chk("pop_data", ext_pop_data_o, tx_m[0]);
      model_step();
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("data_o", data_o, e);
      chk("irq_o", 32'(irq_o), 32'(exp_irq));
      chk("busy_o", 32'(module_busy_o), 32'(exp_busy));
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      reset_i = 0; we_i = 0; address_i = BASE + 32'h10; data_i = 0;
      ext_push_valid_i = 0; ext_pop_ready_i = 0;
   endtask

   task automatic idle();
      idle_inputs(); do_cycle();
   endtask

   task automatic cpu_wr(input logic [7:0] off, input logic [31:0] d);
      we_i = 1; address_i = BASE + 32'(off); data_i = d; do_cycle();
      we_i = 0; address_i = BASE + 32'h10;
   endtask

   task automatic cpu_rd(input logic [7:0] off);
      we_i = 0; address_i = BASE + 32'(off); do_cycle();
      address_i = BASE + 32'h10;
   endtask

   task automatic ext_push(input logic [31:0] d);
      ext_push_valid_i = 1; ext_push_data_i = d; do_cycle(); ext_push_valid_i = 0;
   endtask

   task automatic do_reset();
      idle_inputs(); reset_i = 1; do_cycle(); reset_i = 0;
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  off;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[14];

   initial begin
      idle_inputs();
      we_ram_i = 4'hF;
      ext_push_data_i = 0;
      m_data = 0;
      m_irq_en = 0; m_tx_ovf = 0; m_rx_udf = 0; m_prev_rx = 0;

      // ---- reset state ----
      do_reset();
      chk("rst_data", data_o, 32'h0);
      chk("rst_irq", 32'(irq_o), 32'h0);
      chk("rst_busy", 32'(module_busy_o), 32'h0);

      // ---- table-driven register access ----
      vecs[0]  = '{1'b0, 8'h08, 32'h0,         32'h0000_0005};
      vecs[1]  = '{1'b0, 8'h0C, 32'h0,         32'h0000_0000};
      vecs[2]  = '{1'b1, 8'h00, 32'hA5A5_0001, 32'h0000_0000};
      vecs[3]  = '{1'b0, 8'h08, 32'h0,         32'h0001_0001};
      vecs[4]  = '{1'b0, 8'h10, 32'h0,         32'h0000_0000};
      vecs[5]  = '{1'b1, 8'h0C, 32'h1,         32'h0000_0000};
      vecs[6]  = '{1'b0, 8'h0C, 32'h0,         32'h0000_0001};
      vecs[7]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0000};
      vecs[8]  = '{1'b0, 8'h08, 32'h0,         32'h0001_0021};
      vecs[9]  = '{1'b1, 8'h0C, 32'h5,         32'h0000_0000};
      vecs[10] = '{1'b0, 8'h08, 32'h0,         32'h0001_0001};
      vecs[11] = '{1'b0, 8'h0C, 32'h0,         32'h0000_0001};
      vecs[12] = '{1'b1, 8'h08, 32'hFFFF_FFFF, 32'h0000_0000};
      vecs[13] = '{1'b0, 8'h08, 32'h0,         32'h0001_0001};
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].we) cpu_wr(vecs[i].off, vecs[i].wdata);
         else            cpu_rd(vecs[i].off);
         chk($sformatf("tbl%0d", i), data_o, vecs[i].exp);
      end

      // ---- TX write then external pop ----
      do_reset();
      cpu_wr(8'h00, 32'hA5A5_0001);
      chk("tx_valid", 32'(ext_pop_valid_o), 32'h1);
      chk("tx_head", ext_pop_data_o, 32'hA5A5_0001);
      ext_pop_ready_i = 1; do_cycle(); ext_pop_ready_i = 0;
      chk("tx_busy1", 32'(module_busy_o), 32'h1);
      chk("tx_valid0", 32'(ext_pop_valid_o), 32'h0);
      idle();
      chk("tx_busy0", 32'(module_busy_o), 32'h0);

      // ---- RX fill to full, then drain in order ----
      do_reset();
      for (int i = 1; i <= 8; i++) ext_push(32'(i));
      chk("rx_full_ready", 32'(ext_push_ready_o), 32'h0);
      ext_push(32'd9);
      cpu_rd(8'h08);
      chk("rx_full_status", data_o, 32'h0000_0806);
      for (int i = 1; i <= 8; i++) begin
         cpu_rd(8'h04);
         chk($sformatf("rx_word%0d", i), data_o, 32'(i));
         idle();
      end

      // ---- held RXDATA address pops once ----
      do_reset();
      ext_push(32'd7);
      ext_push(32'd9);
      we_i = 0; address_i = BASE + 4;
      for (int i = 0; i < 5; i++) begin
         do_cycle();
         chk("rx_hold", data_o, 32'd7);
      end
      idle();
      cpu_rd(8'h08);
      chk("rx_hold_status", data_o, 32'h0000_0104);

      // ---- TX overflow and clear ----
      do_reset();
      for (int i = 1; i <= 9; i++) cpu_wr(8'h00, 32'(i));
      cpu_rd(8'h08);
      chk("tx_ovf_set", data_o, 32'h0008_0019);
      cpu_wr(8'h0C, 32'h2);
      cpu_rd(8'h08);
      chk("tx_ovf_clr", data_o, 32'h0008_0009);

      // ---- interrupt on RX data ----
      do_reset();
      cpu_wr(8'h0C, 32'h1);
      idle();
      chk("irq_idle", 32'(irq_o), 32'h0);
      ext_push(32'h55);
      chk("irq_push_edge", 32'(irq_o), 32'h0);
      idle();
      chk("irq_set", 32'(irq_o), 32'h1);
      cpu_rd(8'h04);
      chk("irq_pop_data", data_o, 32'h55);
      idle();
      chk("irq_clr", 32'(irq_o), 32'h0);

      // ---- reset mid-operation ----
      do_reset();
      cpu_wr(8'h0C, 32'h1);
      for (int i = 0; i < 4; i++) begin
         ext_push_valid_i = 1; ext_push_data_i = 32'h100 + 32'(i);
         we_i = 1; address_i = BASE; data_i = 32'h200 + 32'(i);
         do_cycle();
      end
      idle_inputs();
      cpu_rd(8'h08);
      chk("mid_status", data_o, 32'h0004_0400);
      idle();
      chk("mid_irq", 32'(irq_o), 32'h1);
      idle_inputs();
      reset_i = 1; ext_push_valid_i = 1; ext_pop_ready_i = 1;
      we_i = 1; address_i = BASE; data_i = 32'hDEAD;
      do_cycle();
      idle_inputs();
      chk("mid_rst_data", data_o, 32'h0);
      chk("mid_rst_irq", 32'(irq_o), 32'h0);
      #1;
      chk("mid_rst_valid", 32'(ext_pop_valid_o), 32'h0);
      cpu_rd(8'h08);
      chk("mid_rst_status", data_o, 32'h0000_0005);
      cpu_rd(8'h0C);
      chk("mid_rst_ctrl", data_o, 32'h0);

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 1500; n++) begin
         logic [7:0] offs [6];
         offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08;
         offs[3] = 8'h0C; offs[4] = 8'h10; offs[5] = 8'h1C;
         reset_i          = ($urandom_range(0, 199) == 0);
         we_i             = ($urandom_range(0, 2) == 0);
         address_i        = BASE + 32'(offs[$urandom_range(0, 5)]);
         data_i           = $urandom;
         ext_push_valid_i = ($urandom_range(0, 1) == 1);
         ext_push_data_i  = $urandom;
         ext_pop_ready_i  = ($urandom_range(0, 3) == 0);
         do_cycle();
      end
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
